// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. It drives hold/flush of
// PC, IF/ID, ID/EX and EX/MEM for load-use stalls, branch/jump flushes, data-memory
// waits and interrupt drain. All control outputs are combinational from the current
// state and inputs. mem_err is sticky.
// Optional feature: define HAZARD_PERF_CNT_EN to enable the stall_cycles
// performance counter. Without it, o_stall_cycles is tied to zero.

module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_ex_mem_read,
    input  logic [4:0]  i_ex_rt,
    input  logic        i_branch_taken,
    input  logic        i_jump,
    input  logic        i_dmem_req,
    input  logic        i_dmem_ready,
    input  logic        i_irq,
    output logic        o_pc_hold,
    output logic        o_ifid_hold,
    output logic        o_ifid_flush,
    output logic        o_idex_flush,
    output logic        o_exmem_hold,
    output logic        o_irq_ack,
    output logic        o_mem_err,
    output logic [15:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        IRQ_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);
    localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_CYCLES - 1);

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_cnt;
    logic [7:0] w_nextCnt;
    logic [7:0] w_cntInc;
    logic       r_memErr;
    logic       w_setMemErr;
    logic       w_loadUse;
    logic       w_memStall;

    assign w_loadUse  = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                        ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
    assign w_memStall = i_dmem_req && !i_dmem_ready;
    assign w_cntInc   = (r_cnt == 8'hFF) ? r_cnt : (r_cnt + 8'd1);
    assign o_mem_err  = r_memErr;

    // Decode hazards by priority into control outputs and next state/counter values
    always_comb begin
        o_pc_hold    = 1'b0;
        o_ifid_hold  = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_exmem_hold = 1'b0;
        o_irq_ack    = 1'b0;
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_setMemErr  = 1'b0;
        case (r_state)
            RUN: begin
                if (w_memStall) begin
                    o_pc_hold    = 1'b1;
                    o_ifid_hold  = 1'b1;
                    o_exmem_hold = 1'b1;
                    w_nextState  = MEM_WAIT;
                    w_nextCnt    = 8'd1;
                end else if (i_branch_taken) begin
                    o_ifid_flush = 1'b1;
                    o_idex_flush = 1'b1;
                end else if (w_loadUse) begin
                    o_pc_hold    = 1'b1;
                    o_ifid_hold  = 1'b1;
                    o_idex_flush = 1'b1;
                end else if (i_jump) begin
                    o_ifid_flush = 1'b1;
                end else if (i_irq) begin
                    w_nextState  = IRQ_DRAIN;
                    w_nextCnt    = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (i_dmem_ready) begin
                    w_nextState  = RUN;
                end else begin
                    o_pc_hold    = 1'b1;
                    o_ifid_hold  = 1'b1;
                    o_exmem_hold = 1'b1;
                    w_nextCnt    = w_cntInc;
                    if (w_cntInc == TIMEOUT_VAL) begin
                        w_setMemErr = 1'b1;
                        w_nextState = RUN;
                    end
                end
            end
            IRQ_DRAIN: begin
                o_pc_hold    = 1'b1;
                o_ifid_flush = 1'b1;
                if (w_memStall) begin
                    o_ifid_hold  = 1'b1;
                    o_exmem_hold = 1'b1;
                end else if (r_cnt >= DRAIN_LAST) begin
                    o_irq_ack    = 1'b1;
                    w_nextState  = RUN;
                    w_nextCnt    = 8'd0;
                end else begin
                    w_nextCnt    = w_cntInc;
                end
            end
            default: begin
                w_nextState = RUN;
                w_nextCnt   = 8'd0;
            end
        endcase
    end

    // Register sequencer state, shared wait/drain counter and sticky memory error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= RUN;
            r_cnt    <= 8'd0;
            r_memErr <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (w_setMemErr) begin
                r_memErr <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stallCycles;

    // Count every cycle the PC is held, saturating at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCycles <= 16'h0000;
        end else if (o_pc_hold && (r_stallCycles != 16'hFFFF)) begin
            r_stallCycles <= r_stallCycles + 16'd1;
        end
    end

    assign o_stall_cycles = r_stallCycles;
`else
    assign o_stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. Inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
// Control bits are packed as {pc_hold, ifid_hold, ifid_flush, idex_flush,
// exmem_hold, irq_ack, mem_err}.

module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        exMemRead;
    logic [4:0]  exRt;
    logic        branchTaken;
    logic        jump;
    logic        dmemReq;
    logic        dmemReady;
    logic        irq;
    logic        pcHold;
    logic        ifidHold;
    logic        ifidFlush;
    logic        idexFlush;
    logic        exmemHold;
    logic        irqAck;
    logic        memErr;
    logic [15:0] stallCycles;

    int vectorCount = 0;
    int missCount   = 0;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] EXP_PERF = 32'd6;
`else
    localparam logic [31:0] EXP_PERF = 32'd0;
`endif

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT  (64),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_id_rs        (idRs),
        .i_id_rt        (idRt),
        .i_ex_mem_read  (exMemRead),
        .i_ex_rt        (exRt),
        .i_branch_taken (branchTaken),
        .i_jump         (jump),
        .i_dmem_req     (dmemReq),
        .i_dmem_ready   (dmemReady),
        .i_irq          (irq),
        .o_pc_hold      (pcHold),
        .o_ifid_hold    (ifidHold),
        .o_ifid_flush   (ifidFlush),
        .o_idex_flush   (idexFlush),
        .o_exmem_hold   (exmemHold),
        .o_irq_ack      (irqAck),
        .o_mem_err      (memErr),
        .o_stall_cycles (stallCycles)
    );

    // Free-running 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ctl();
        return {25'd0, pcHold, ifidHold, ifidFlush, idexFlush, exmemHold, irqAck, memErr};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
        end
    endtask

    // One cycle: drive inputs at the falling edge, then settle before sampling
    task automatic applyStimulus(input logic [4:0] aRs, input logic [4:0] aRt,
                                 input logic aMr, input logic [4:0] aExRt,
                                 input logic aBr, input logic aJmp, input logic aReq,
                                 input logic aRdy, input logic aIrq);
        @(negedge clk);
        idRs        = aRs;
        idRt        = aRt;
        exMemRead   = aMr;
        exRt        = aExRt;
        branchTaken = aBr;
        jump        = aJmp;
        dmemReq     = aReq;
        dmemReady   = aRdy;
        irq         = aIrq;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        idRs = '0; idRt = '0; exMemRead = 1'b0; exRt = '0; branchTaken = 1'b0;
        jump = 1'b0; dmemReq = 1'b0; dmemReady = 1'b0; irq = 1'b0;

        // Reset state
        @(negedge clk); #1;
        checkOutput("resetCtl", ctl(), 32'b0000000);
        checkOutput("resetPerf", {16'd0, stallCycles}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // T1 load-use on rs, one bubble then quiet
        applyStimulus(5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1LoadUseRs", ctl(), 32'b1101000);
        idleCycle();
        checkOutput("t1After", ctl(), 32'b0000000);

        // T3 five-cycle memory wait released on the ready cycle
        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("t3Freeze", ctl(), 32'b1100100);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t3Release", ctl(), 32'b0000000);

        // T6 performance count after T1 and T3
        checkOutput("t6Perf", {16'd0, stallCycles}, EXP_PERF);
        idleCycle();
        checkOutput("t3Idle", ctl(), 32'b0000000);

        // Load-use on rt, zero-register exclusion, ready access in RUN
        applyStimulus(5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("loadUseRt", ctl(), 32'b1101000);
        applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("loadUseR0", ctl(), 32'b0000000);
        applyStimulus(5'd4, 5'd5, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("noDependency", ctl(), 32'b0000000);
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("readyInRun", ctl(), 32'b0000000);

        // T2 branch beats load-use; jump alone; load-use beats jump
        applyStimulus(5'd0, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2BranchWins", ctl(), 32'b0011000);
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("jumpOnly", ctl(), 32'b0010000);
        applyStimulus(5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("loadUseOverJump", ctl(), 32'b1101000);

        // MEM_WAIT ignores branch and irq
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("waitEnter", ctl(), 32'b1100100);
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("waitIgnoresBranch", ctl(), 32'b1100100);
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("waitReadyIgnoresBranch", ctl(), 32'b0000000);

        // T5 interrupt drain, ack on the third bubble
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("irqEntry", ctl(), 32'b0000000);
        idleCycle();
        checkOutput("drain1", ctl(), 32'b1010000);
        idleCycle();
        checkOutput("drain2", ctl(), 32'b1010000);
        idleCycle();
        checkOutput("drain3Ack", ctl(), 32'b1010010);
        idleCycle();
        checkOutput("drainDone", ctl(), 32'b0000000);

        // Held irq: one quiet RUN cycle between drains
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("heldIrqEntry", ctl(), 32'b0000000);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("heldDrain", ctl(), 32'b1010000);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("heldAck", ctl(), 32'b1010010);
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("heldGapRun", ctl(), 32'b0000000);
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("heldReenter", ctl(), 32'b1010000);
        idleCycle();
        checkOutput("heldDrain2", ctl(), 32'b1010000);
        idleCycle();
        checkOutput("heldAck2", ctl(), 32'b1010010);

        // Memory stall during drain pauses the drain count
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("stallDrainEntry", ctl(), 32'b0000000);
        idleCycle();
        checkOutput("stallDrain1", ctl(), 32'b1010000);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("drainFrozen", ctl(), 32'b1110100);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("drainResume", ctl(), 32'b1010000);
        idleCycle();
        checkOutput("drainResumeAck", ctl(), 32'b1010010);
        idleCycle();
        checkOutput("drainResumeDone", ctl(), 32'b0000000);

        // Reset in mid-drain returns to RUN with no ack
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idleCycle();
        checkOutput("preResetDrain", ctl(), 32'b1010000);
        #1 reset = 1'b0;
        #1 checkOutput("resetMidDrain", ctl(), 32'b0000000);
        idleCycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput("noAckAfterReset", ctl(), 32'b0000000);
        end

        // T4 memory timeout raises sticky mem_err
        for (int i = 0; i < 64; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("t4Waiting", ctl(), 32'b1100100);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t4Timeout", ctl(), 32'b1100101);
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4Released", ctl(), 32'b0000001);
        idleCycle();
        checkOutput("t4Sticky", ctl(), 32'b0000001);
        #1 reset = 1'b0;
        #1 checkOutput("t4ResetClears", ctl(), 32'b0000000);
        idleCycle();
        reset = 1'b1;
        idleCycle();
        checkOutput("t4AfterReset", ctl(), 32'b0000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
